// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
// The optional subtract mode is enabled by defining BCD_SUB_EN.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;
    localparam digit_t BCD_ADJ = 4'd6;

    function automatic digit_t nines_comp(input digit_t d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add with decimal adjust: t = a + b + c, corrected by +6 when t exceeds 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  digit_t a_d,
    input  digit_t b_d,
    input  logic   c_in,
    output digit_t s_d,
    output logic   c_out
);

    logic [4:0] t;
    logic [4:0] t_adj;

    always_comb begin
        t     = {1'b0, a_d} + {1'b0, b_d} + {4'b0, c_in};
        t_adj = t + {1'b0, BCD_ADJ};
        if (t > {1'b0, BCD_MAX}) begin
            s_d   = t_adj[3:0];
            c_out = 1'b1;
        end else begin
            s_d   = t[3:0];
            c_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock LSD first, start/busy/done handshake.
// Defining BCD_SUB_EN adds a 'sub' input selecting a - b via 9's complement plus forced carry.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                carry_in,
`ifdef BCD_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                carry_out
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    digit_t           dig_s;
    logic             dig_c;

    bcd_digit_add u_digit (
        .a_d  (a_q[4*idx_q +: 4]),
        .b_d  (b_q[4*idx_q +: 4]),
        .c_in (carry_q),
        .s_d  (dig_s),
        .c_out(dig_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_in;
`ifdef BCD_SUB_EN
                    // Subtraction stores the 9's complement of b so RUN stays a plain add.
                    if (sub) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            b_d[4*i +: 4] = nines_comp(b[4*i +: 4]);
                        end
                        carry_d = 1'b1;
                    end
`endif
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = dig_s;
                carry_d             = dig_c;
                idx_d               = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = dig_c;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4); subtract cases run when BCD_SUB_EN is defined.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
`ifdef BCD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   exp_q[$];
    int           cyc = 0;
    int           done_cnt = 0;
    int           last_done_cyc = 0;
    int           prev_done_cyc = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
`ifdef BCD_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry_out(carry_out)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // reference model: decimal arithmetic on integers
    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        int m = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r += int'(v[4*i +: 4]) * m;
            m *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [W:0] model_add(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                             input logic oc);
        int t = bcd2int(oa) + bcd2int(ob) + int'(oc);
        return {(t >= 10000), int2bcd(t % 10000)};
    endfunction

    // scoreboard: every done pulse must pop a pending expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            logic [W:0] e;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            done_cnt++;
            check_val("busy_low_in_done", busy, 0);
            check_val("done_has_expect", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("sum", sum, e[W-1:0]);
                check_val("carry_out", carry_out, e[W]);
            end
        end
    end

    // drivers
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_timeout", (n < 50), 1);
    endtask

    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         input logic [W:0] e);
        wait_idle();
`ifdef BCD_SUB_EN
        sub = 1'b0;
`endif
        a = oa;
        b = ob;
        carry_in = oc;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

`ifdef BCD_SUB_EN
    task automatic do_sub(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input logic [W:0] e);
        wait_idle();
        sub = 1'b1;
        a = oa;
        b = ob;
        carry_in = oc;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        sub = 1'b0;
    endtask
`endif

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        int cnt0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        carry_in = 1'b0;
`ifdef BCD_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_sum", sum, 0);
        check_val("rst_cout", carry_out, 0);
        rst = 1'b0;

        // 1234 + 4321 with latency measurement
        @(negedge clk);
        a = 16'h1234;
        b = 16'h4321;
        carry_in = 1'b0;
        start = 1'b1;
        exp_q.push_back({1'b0, 16'h5555});
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check_val("busy_run", busy, 1);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("latency", n, DIGITS + 1);
        drain();

        // carry ripple through all digits, carry_in into digit 0
        do_op(16'h9999, 16'h0001, 1'b0, {1'b1, 16'h0000});
        do_op(16'h0000, 16'h0000, 1'b1, {1'b0, 16'h0001});
        drain();

        // start held through RUN and DONE with a changing mid-op
        wait_idle();
        cnt0 = done_cnt;
        a = 16'h1234;
        b = 16'h4321;
        carry_in = 1'b0;
        start = 1'b1;
        exp_q.push_back({1'b0, 16'h5555});
        @(negedge clk);
        a = 16'h9999;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("held_start_done", done, 1);
        @(negedge clk);
        start = 1'b0;
        check_val("start_in_done_ignored", busy, 0);
        repeat (6) @(negedge clk);
        check_val("held_start_one_done", done_cnt - cnt0, 1);
        drain();

        // back-to-back throughput
        do_op(16'h0999, 16'h0001, 1'b0, {1'b0, 16'h1000});
        do_op(16'h5000, 16'h5000, 1'b0, {1'b1, 16'h0000});
        drain();
        check_val("done_spacing", last_done_cyc - prev_done_cyc, DIGITS + 2);

        // reset in the 2nd RUN cycle aborts without a done pulse
        wait_idle();
        cnt0 = done_cnt;
        a = 16'h5678;
        b = 16'h1111;
        carry_in = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_sum", sum, 0);
        check_val("abort_cout", carry_out, 0);
        repeat (8) @(negedge clk);
        check_val("abort_no_done", done_cnt - cnt0, 0);

`ifdef BCD_SUB_EN
        do_sub(16'h5000, 16'h1234, 1'b0, {1'b1, 16'h3766});
        do_sub(16'h1234, 16'h5000, 1'b1, {1'b0, 16'h6234});
        do_op(16'h1234, 16'h5000, 1'b0, {1'b0, 16'h6234});
        drain();
`endif

        // random valid BCD operands against the integer model
        for (int i = 0; i < 8; i++) begin
            ra = int2bcd($urandom_range(0, 9999));
            rb = int2bcd($urandom_range(0, 9999));
            rc = 1'($urandom_range(0, 1));
            do_op(ra, rb, rc, model_add(ra, rb, rc));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
